// File: rtl/maxi_rw_sequencer_if.sv
// MAXIGP0 request/response channels plus the shared register-access port.
// The slave modport is the sequencer's view; master is the bus/regfile side.
interface maxi_rw_sequencer_if #(
  parameter int ID_WIDTH   = 12,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  AR__ENA;
  logic [ADDR_WIDTH-1:0] AR_addr;
  logic [ID_WIDTH-1:0]   AR_id;
  logic [LEN_WIDTH-1:0]  AR_len;
  logic                  AR__RDY;

  logic                  AW__ENA;
  logic [ADDR_WIDTH-1:0] AW_addr;
  logic [ID_WIDTH-1:0]   AW_id;
  logic [LEN_WIDTH-1:0]  AW_len;
  logic                  AW__RDY;

  logic                  W__ENA;
  logic [DATA_WIDTH-1:0] W_data;
  logic [ID_WIDTH-1:0]   W_id;
  logic                  W_last;
  logic                  W__RDY;

  logic                  R__ENA;
  logic [DATA_WIDTH-1:0] R_data;
  logic [ID_WIDTH-1:0]   R_id;
  logic                  R_last;
  logic [1:0]            R_resp;
  logic                  R__RDY;

  logic                  B__ENA;
  logic [ID_WIDTH-1:0]   B_id;
  logic [1:0]            B_resp;
  logic                  B__RDY;

  logic                  regRead__ENA;
  logic [ADDR_WIDTH-1:0] regRead_addr;
  logic                  regRead__RDY;
  logic [DATA_WIDTH-1:0] regReadData;

  logic                  regWrite__ENA;
  logic [ADDR_WIDTH-1:0] regWrite_addr;
  logic [DATA_WIDTH-1:0] regWrite_data;
  logic                  regWrite__RDY;

  modport slave (
    input  AR__ENA, AR_addr, AR_id, AR_len,
    output AR__RDY,
    input  AW__ENA, AW_addr, AW_id, AW_len,
    output AW__RDY,
    input  W__ENA, W_data, W_id, W_last,
    output W__RDY,
    output R__ENA, R_data, R_id, R_last, R_resp,
    input  R__RDY,
    output B__ENA, B_id, B_resp,
    input  B__RDY,
    output regRead__ENA, regRead_addr,
    input  regRead__RDY, regReadData,
    output regWrite__ENA, regWrite_addr, regWrite_data,
    input  regWrite__RDY
  );

  modport master (
    output AR__ENA, AR_addr, AR_id, AR_len,
    input  AR__RDY,
    output AW__ENA, AW_addr, AW_id, AW_len,
    input  AW__RDY,
    output W__ENA, W_data, W_id, W_last,
    input  W__RDY,
    input  R__ENA, R_data, R_id, R_last, R_resp,
    output R__RDY,
    input  B__ENA, B_id, B_resp,
    output B__RDY,
    input  regRead__ENA, regRead_addr,
    output regRead__RDY, regReadData,
    input  regWrite__ENA, regWrite_addr, regWrite_data,
    output regWrite__RDY
  );
endinterface

// File: rtl/maxi_rw_sequencer.sv
// Serialises MAXIGP0 read/write bursts onto one register-access port,
// round-robin between directions, generating R beats and B responses.
module maxi_rw_sequencer #(
  parameter int ID_WIDTH   = 12,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input logic CLK,
  input logic nRST,
  maxi_rw_sequencer_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0]  ONE    = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE, RD_BURST, WR_BURST, WR_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  last_was_write_q, last_was_write_d;
  logic                  err_q, err_d;

  logic rd_grant, wr_grant;
  logic rd_beat, wr_beat;
  logic cnt_zero, id_hit;

  // Read wins a tie unless it also won the previous grant
  assign rd_grant = bus.AR__ENA && (!bus.AW__ENA || last_was_write_q);
  assign wr_grant = bus.AW__ENA && !rd_grant;
  assign rd_beat  = bus.R__RDY && bus.regRead__RDY;
  assign wr_beat  = bus.W__ENA && bus.regWrite__RDY;
  assign cnt_zero = (count_q == '0);
  assign id_hit   = (bus.W_id == id_q);

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      id_q             <= '0;
      count_q          <= '0;
      last_was_write_q <= 1'b1;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      id_q             <= id_d;
      count_q          <= count_d;
      last_was_write_q <= last_was_write_d;
      err_q            <= err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    id_d             = id_q;
    count_d          = count_q;
    last_was_write_d = last_was_write_q;
    err_d            = err_q;

    bus.AR__RDY       = 1'b0;
    bus.AW__RDY       = 1'b0;
    bus.W__RDY        = 1'b0;
    bus.R__ENA        = 1'b0;
    bus.R_data        = '0;
    bus.R_id          = '0;
    bus.R_last        = 1'b0;
    bus.R_resp        = 2'b00;
    bus.B__ENA        = 1'b0;
    bus.B_id          = '0;
    bus.B_resp        = 2'b00;
    bus.regRead__ENA  = 1'b0;
    bus.regRead_addr  = '0;
    bus.regWrite__ENA = 1'b0;
    bus.regWrite_addr = '0;
    bus.regWrite_data = '0;

    unique case (state_q)
      IDLE: begin
        // Async reset parks the FSM here; keep readies quiet while held
        bus.AR__RDY = rd_grant && !nRST;
        bus.AW__RDY = wr_grant && !nRST;
        if (rd_grant) begin
          addr_d           = bus.AR_addr;
          id_d             = bus.AR_id;
          count_d          = bus.AR_len;
          last_was_write_d = 1'b0;
          state_d          = RD_BURST;
        end else if (wr_grant) begin
          addr_d           = bus.AW_addr;
          id_d             = bus.AW_id;
          count_d          = bus.AW_len;
          err_d            = 1'b0;
          last_was_write_d = 1'b1;
          state_d          = WR_BURST;
        end
      end
      RD_BURST: begin
        bus.regRead__ENA = rd_beat;
        bus.regRead_addr = addr_q;
        bus.R__ENA       = rd_beat;
        bus.R_data       = bus.regReadData;
        bus.R_id         = id_q;
        bus.R_last       = cnt_zero;
        if (rd_beat) begin
          addr_d = addr_q + STRIDE;
          if (cnt_zero) state_d = IDLE;
          else count_d = count_q - ONE;
        end
      end
      WR_BURST: begin
        bus.W__RDY        = bus.regWrite__RDY;
        bus.regWrite_addr = addr_q;
        bus.regWrite_data = bus.W_data;
        if (wr_beat) begin
          bus.regWrite__ENA = id_hit;
          if (!id_hit || (bus.W_last != cnt_zero)) err_d = 1'b1;
          addr_d = addr_q + STRIDE;
          // Beat count, not W_last, terminates the burst
          if (cnt_zero) state_d = WR_RESP;
          else count_d = count_q - ONE;
        end
      end
      WR_RESP: begin
        bus.B__ENA = 1'b1;
        bus.B_id   = id_q;
        bus.B_resp = err_q ? 2'b10 : 2'b00;
        if (bus.B__RDY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/maxi_rw_sequencer.md
Name: maxi_rw_sequencer

Overview:
- Serialises the MAXIGP0 AR/AW/W request streams onto a single shared register-access port, one burst at a time.
- Generates the matching R beats and B responses.
- Arbitrates round-robin between the read and write directions.
- Sits between the Zynq MAXIGP0 MaxiO/MaxiI channels and the portal/user register file, replacing per-direction FIFO steering with one sequenced access path.

Parameters:
- ID_WIDTH, 12, AXI id width on AR/AW/W/R/B.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; beat address stride is DATA_WIDTH/8.
- LEN_WIDTH, 4, burst length field (beats = len+1).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; asynchronous, active-high (asserted when 1).
- AR__ENA / AR$addr / AR$id / AR$len  in  1/ADDR_WIDTH/ID_WIDTH/LEN_WIDTH  read address request.
- AR__RDY  out  1  read address accepted this cycle when high with AR__ENA.
- AW__ENA / AW$addr / AW$id / AW$len  in  1/ADDR_WIDTH/ID_WIDTH/LEN_WIDTH  write address request.
- AW__RDY  out  1  write address ready.
- W__ENA / W$data / W$id / W$last  in  1/DATA_WIDTH/ID_WIDTH/1  write data beat.
- W__RDY  out  1  write data ready.
- R__ENA / R$data / R$id / R$last / R$resp  out  1/DATA_WIDTH/ID_WIDTH/1/2  read data beat.
- R__RDY  in  1  read beat consumer ready.
- B__ENA / B$id / B$resp  out  1/ID_WIDTH/2  write response.
- B__RDY  in  1  write response consumer ready.
- regRead__ENA / regRead$addr  out  1/ADDR_WIDTH  register read strobe and address.
- regRead__RDY  in  1  register file can accept a read.
- regReadData  in  DATA_WIDTH  read data, valid combinationally in the regRead__ENA cycle.
- regWrite__ENA / regWrite$addr / regWrite$data  out  1/ADDR_WIDTH/DATA_WIDTH  register write.
- regWrite__RDY  in  1  register file can accept a write.

Behaviour:
- States: IDLE, RD_BURST, WR_BURST, WR_RESP.
- Registers: state, addr, id, count (LEN_WIDTH), lastWasWrite, err.
- Reset (nRST=1, async):
  - state=IDLE, count=0, err=0, lastWasWrite=1 (read wins the first tie).
  - All __ENA/__RDY outputs 0; data outputs 0.
  - Reset mid-burst abandons the burst; no R or B is emitted for it.
- IDLE arbitration:
  - Read is granted if AR__ENA && (!AW__ENA || lastWasWrite).
  - Otherwise write is granted if AW__ENA.
  - AR__RDY = IDLE && read grant; AW__RDY = IDLE && write grant. Never both high in one cycle.
- On AR accept: latch addr/id, count=AR$len, lastWasWrite=0, go to RD_BURST.
- On AW accept: latch addr/id, count=AW$len, err=0, lastWasWrite=1, go to WR_BURST.
- Minimum latency is 1 cycle: address accepted in cycle N, first beat possible in N+1. Back-to-back bursts need one IDLE cycle between them.
- RD_BURST:
  - regRead__ENA = R__ENA = R__RDY && regRead__RDY.
  - R$data=regReadData, R$id=id, R$resp=0, R$last=(count==0); regRead$addr=addr.
  - Per beat: addr += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH), count -= 1.
  - Last beat returns to IDLE.
- WR_BURST:
  - W__RDY = regWrite__RDY.
  - Per accepted beat:
    - If W$id==id: regWrite__ENA=1 with addr/W$data.
    - If W$id!=id: no register write and err=1.
    - If W$last != (count==0): err=1.
    - addr += stride; count -= 1.
  - The beat with count==0 ends the burst, go to WR_RESP. W$last alone does not end it.
- WR_RESP:
  - B__ENA=1, B$id=id, B$resp = err ? 2'b10 : 2'b00.
  - On B__RDY go to IDLE.
- count never underflows: the terminal beat always exits the state.
- Stalls: R__RDY or regRead__RDY low holds all state; no read is issued without R__RDY.

Test Plan:
- Single read: AR addr=0x40 id=5 len=0, R__RDY=1 → cycle+1: regRead$addr=0x40, R__ENA=1, R$id=5, R$last=1, R$resp=0; state returns to IDLE.
- 4-beat read with R__RDY low in beat 2 for 3 cycles → regRead addrs 0x100,0x104,0x108,0x10C issued exactly once each; R$last only on the 4th beat.
- AR and AW both asserted from reset, each len=0 → read granted first, write second; a repeated simultaneous pair alternates read, write, read, write.
- Write burst AW addr=0x20 len=1 id=3, W beats (0xA,last=0), (0xB,last=1) → regWrite (0x20,0xA), (0x24,0xB); B__ENA with B$id=3, B$resp=0.
- Write len=1 with W$last=1 on the first beat → both beats written; B$resp=2. Separately, a mismatched W$id beat is not written and gives B$resp=2.
- Assert nRST during beat 2 of a 4-beat read → outputs 0 immediately; no further R; next AR is accepted normally after release.
